reg_dump_ctrl: RTL and testbench
================================

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 The block SHALL take one parameter: PULAR_ZERO, default 1, meaning that register 0 is never emitted (it always reads zero).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- Clock, in, 1: rising-edge clock.
- Reset_n, in, 1: synchronous reset, active-low.
- Iniciar, in, 1: single-cycle start pulse.
- IndiceInicial, in, 5: first register index of the dump range.
- IndiceFinal, in, 5: last register index of the dump range.
- regLeitura, out, 5: read address driven to a register-file read port.
- DadosLeitura, in, 32: combinational read data from that port.
- SaidaValida, out, 1: output word valid.
- SaidaPronta, in, 1: consumer ready.
- SaidaDados, out, 32: output word.
- SaidaIndice, out, 5: register index of the output word.
- SaidaUltimo, out, 1: marks the final word of the dump.
- Ocupado, out, 1: dump in progress.
- Erro, out, 1: sticky invalid-range flag.

Function
REQ-004 The FSM SHALL have the states OCIOSO, LER, ENVIAR and CHECKSUM; CHECKSUM exists only under the macro in REQ-018.
REQ-005 In OCIOSO, a cycle with Iniciar=1 SHALL latch the range and clear Erro.
- The effective start index is IndiceInicial, or 1 when PULAR_ZERO=1 and IndiceInicial=0.
REQ-006 If the effective start index is greater than IndiceFinal, the FSM SHALL set Erro=1, stay in OCIOSO and emit no words.
- Otherwise it SHALL go to LER.
REQ-007 In LER, regLeitura SHALL equal the current index.
- At the next edge, DadosLeitura SHALL be registered into SaidaDados and the index into SaidaIndice.
- SaidaValida SHALL be set and the FSM SHALL go to ENVIAR.
REQ-008 Latency: the first SaidaValida SHALL be asserted 2 cycles after the Iniciar cycle; peak throughput SHALL be one word per 2 cycles.
REQ-009 In ENVIAR, SaidaDados, SaidaIndice and SaidaUltimo SHALL stay stable while SaidaValida=1 and SaidaPronta=0.
REQ-010 A handshake SHALL occur on a cycle with SaidaValida and SaidaPronta both high; on handshake, SaidaValida SHALL drop at the next edge.
- If the index equals IndiceFinal, the FSM SHALL go to OCIOSO (or to CHECKSUM).
- Otherwise the index SHALL be incremented and the FSM SHALL go to LER.
REQ-011 SaidaUltimo SHALL be 1 only on the final word of the dump.
REQ-012 The index SHALL never wrap: with IndiceFinal=31 the dump SHALL stop after register 31.
REQ-013 Ocupado SHALL be 1 in every state except OCIOSO; Iniciar SHALL be ignored while Ocupado=1.
REQ-014 A register-file write that lands during a dump SHALL be reflected only if it lands before that register's LER cycle; no other coherence is provided.
REQ-015 regLeitura SHALL be 0 whenever the FSM is in OCIOSO.

Reset
REQ-016 When Reset_n=0 at a rising edge, the block SHALL enter OCIOSO, aborting any dump, with:
- SaidaValida=0, SaidaUltimo=0, Ocupado=0, Erro=0;
- SaidaDados=0, SaidaIndice=0, regLeitura=0;
- checksum accumulator=0.
REQ-017 Reset SHALL take priority over Iniciar and over a handshake in the same cycle.

Configuration
REQ-018 When REG_DUMP_CHECKSUM_EN is defined:
- The block SHALL XOR-accumulate every emitted data word.
- After the last register handshake, the FSM SHALL enter CHECKSUM and present one extra word with SaidaDados=accumulator, SaidaIndice=0 and SaidaUltimo=1, under the same handshake rules.
- SaidaUltimo SHALL then be 0 on the last register word.
- The accumulator SHALL be cleared when a dump starts.
REQ-019 When REG_DUMP_CHECKSUM_EN is not defined, the CHECKSUM state and the accumulator SHALL be absent, and the dump SHALL end on the last register.

Structure
REQ-020 A shared package reg_dump_pkg SHALL hold:
- the FSM state enum;
- LARGURA_DADO=32;
- LARGURA_END=5;
- NUM_REGS=32.
REQ-021 The block SHALL be a single module with no sub-module; the checksum SHALL be inline logic under the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios (registers preloaded with Rk=0x100+k, SaidaPronta=1 unless stated):
- Iniciar with 3..5 -> words (0x103,3), (0x104,4), (0x105,5); SaidaUltimo only on index 5; first SaidaValida 2 cycles after Iniciar.
- Range 0..0 with PULAR_ZERO=1 -> Erro=1, no SaidaValida, Ocupado stays 0; the next valid Iniciar clears Erro.
- Range 30..31 with SaidaPronta held 0 for 5 cycles -> word (0x11E,30) stable for all 5 cycles; dump ends after index 31 with no wrap.
- Reset_n=0 in the middle of a 1..31 dump -> next cycle all outputs 0, FSM in OCIOSO; a second Iniciar during the dump is ignored.
- With REG_DUMP_CHECKSUM_EN, range 1..2 -> words 0x101, 0x102, then 0x003 at index 0 with SaidaUltimo=1.

Source files
------------

// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump controller.
//   estado_t     : dump FSM states (CHECKSUM only when REG_DUMP_CHECKSUM_EN
//                  is defined)
//   LARGURA_DADO : register data width
//   LARGURA_END  : register index / address width
//   NUM_REGS     : number of registers in the dumped register file
package reg_dump_pkg;

    localparam int LARGURA_DADO = 32;
    localparam int LARGURA_END  = 5;
    localparam int NUM_REGS     = 32;

`ifdef REG_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LER      = 2'd1,
        ENVIAR   = 2'd2,
        CHECKSUM = 2'd3
    } estado_t;
`else
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LER      = 2'd1,
        ENVIAR   = 2'd2
    } estado_t;
`endif

endpackage

// File: rtl/reg_dump_ctrl.sv
// Register dump controller: on a start pulse, walks a register index range,
// reads each register through a combinational register-file read port and
// streams the words out over a valid/ready interface.
//
// Optional feature macro: REG_DUMP_CHECKSUM_EN -- appends one XOR checksum
// word (index 0, SaidaUltimo=1) after the last register word.
//
// Ports:
//   Clock         in   1  rising-edge clock
//   Reset_n       in   1  synchronous reset, active-low
//   Iniciar       in   1  start pulse (ignored while Ocupado=1)
//   IndiceInicial in   5  first register index of the range
//   IndiceFinal   in   5  last register index of the range
//   regLeitura    out  5  register-file read address (0 while idle)
//   DadosLeitura  in  32  combinational read data for regLeitura
//   SaidaValida   out  1  output word valid
//   SaidaPronta   in   1  consumer ready
//   SaidaDados    out 32  output word
//   SaidaIndice   out  5  register index of the output word
//   SaidaUltimo   out  1  final word of the dump
//   Ocupado       out  1  dump in progress
//   Erro          out  1  sticky invalid-range flag, cleared by next start
module reg_dump_ctrl
    import reg_dump_pkg::*;
#(
    parameter bit PULAR_ZERO = 1'b1
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic                    Iniciar,
    input  logic [LARGURA_END-1:0]  IndiceInicial,
    input  logic [LARGURA_END-1:0]  IndiceFinal,
    output logic [LARGURA_END-1:0]  regLeitura,
    input  logic [LARGURA_DADO-1:0] DadosLeitura,
    output logic                    SaidaValida,
    input  logic                    SaidaPronta,
    output logic [LARGURA_DADO-1:0] SaidaDados,
    output logic [LARGURA_END-1:0]  SaidaIndice,
    output logic                    SaidaUltimo,
    output logic                    Ocupado,
    output logic                    Erro
);

    estado_t                 estado_r;
    estado_t                 estado_nx_s;
    logic [LARGURA_END-1:0]  indice_r;
    logic [LARGURA_END-1:0]  indice_nx_s;
    logic [LARGURA_END-1:0]  final_r;
    logic [LARGURA_END-1:0]  inicio_efetivo_s;
    logic                    inicio_invalido_s;
    logic                    handshake_s;
    logic                    ultimo_carga_s;
    logic [LARGURA_END-1:0]  reg_leitura_r;
    logic                    valida_r;
    logic [LARGURA_DADO-1:0] dados_r;
    logic [LARGURA_END-1:0]  indice_saida_r;
    logic                    ultimo_r;
    logic                    ocupado_r;
    logic                    erro_r;
`ifdef REG_DUMP_CHECKSUM_EN
    logic [LARGURA_DADO-1:0] acumulador_r;
`endif

    assign regLeitura  = reg_leitura_r;
    assign SaidaValida = valida_r;
    assign SaidaDados  = dados_r;
    assign SaidaIndice = indice_saida_r;
    assign SaidaUltimo = ultimo_r;
    assign Ocupado     = ocupado_r;
    assign Erro        = erro_r;

    // Range decode, handshake detect and last-word flag for the word being loaded.
    always_comb begin
        if (PULAR_ZERO && (IndiceInicial == 5'd0)) begin
            inicio_efetivo_s = 5'd1;
        end else begin
            inicio_efetivo_s = IndiceInicial;
        end
        inicio_invalido_s = (inicio_efetivo_s > IndiceFinal);
        handshake_s       = valida_r & SaidaPronta;
`ifdef REG_DUMP_CHECKSUM_EN
        // The checksum word carries the end-of-dump marker instead.
        ultimo_carga_s    = 1'b0;
`else
        ultimo_carga_s    = (indice_r == final_r);
`endif
    end

    // Next-state and next-index logic of the dump FSM.
    always_comb begin
        estado_nx_s = estado_r;
        indice_nx_s = indice_r;
        case (estado_r)
            OCIOSO: begin
                if (Iniciar && !inicio_invalido_s) begin
                    estado_nx_s = LER;
                    indice_nx_s = inicio_efetivo_s;
                end else begin
                    estado_nx_s = OCIOSO;
                end
            end
            LER: begin
                estado_nx_s = ENVIAR;
            end
            ENVIAR: begin
                if (!handshake_s) begin
                    estado_nx_s = ENVIAR;
                end else if (indice_r == final_r) begin
                    // Index stops at the final register, so 31 never wraps to 0.
`ifdef REG_DUMP_CHECKSUM_EN
                    estado_nx_s = CHECKSUM;
`else
                    estado_nx_s = OCIOSO;
`endif
                end else begin
                    estado_nx_s = LER;
                    indice_nx_s = indice_r + 5'd1;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CHECKSUM: begin
                if (handshake_s) begin
                    estado_nx_s = OCIOSO;
                end else begin
                    estado_nx_s = CHECKSUM;
                end
            end
`endif
            default: begin
                estado_nx_s = OCIOSO;
                indice_nx_s = 5'd0;
            end
        endcase
    end

    // State, index, read address and output word registers.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            estado_r       <= OCIOSO;
            indice_r       <= 5'd0;
            final_r        <= 5'd0;
            reg_leitura_r  <= 5'd0;
            valida_r       <= 1'b0;
            dados_r        <= 32'h0000_0000;
            indice_saida_r <= 5'd0;
            ultimo_r       <= 1'b0;
            ocupado_r      <= 1'b0;
            erro_r         <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
            acumulador_r   <= 32'h0000_0000;
`endif
        end else begin
            estado_r      <= estado_nx_s;
            indice_r      <= indice_nx_s;
            ocupado_r     <= (estado_nx_s != OCIOSO);
            // Address is presented exactly during the LER cycle, else parked at 0.
            reg_leitura_r <= (estado_nx_s == LER) ? indice_nx_s : 5'd0;
            case (estado_r)
                OCIOSO: begin
                    if (Iniciar) begin
                        erro_r  <= inicio_invalido_s;
                        final_r <= IndiceFinal;
`ifdef REG_DUMP_CHECKSUM_EN
                        acumulador_r <= 32'h0000_0000;
`endif
                    end
                end
                LER: begin
                    dados_r        <= DadosLeitura;
                    indice_saida_r <= indice_r;
                    valida_r       <= 1'b1;
                    ultimo_r       <= ultimo_carga_s;
`ifdef REG_DUMP_CHECKSUM_EN
                    acumulador_r   <= acumulador_r ^ DadosLeitura;
`endif
                end
                ENVIAR: begin
                    if (handshake_s) begin
                        valida_r <= 1'b0;
                        ultimo_r <= 1'b0;
                    end
                end
`ifdef REG_DUMP_CHECKSUM_EN
                CHECKSUM: begin
                    // First cycle loads the checksum word, then wait for its handshake.
                    if (!valida_r) begin
                        dados_r        <= acumulador_r;
                        indice_saida_r <= 5'd0;
                        ultimo_r       <= 1'b1;
                        valida_r       <= 1'b1;
                    end else if (handshake_s) begin
                        valida_r <= 1'b0;
                        ultimo_r <= 1'b0;
                    end
                end
`endif
                default: begin
                    valida_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
module tb_reg_dump_ctrl;
    import reg_dump_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        iniciar;
    logic [4:0]  ind_ini;
    logic [4:0]  ind_fim;
    logic [4:0]  reg_leitura;
    logic [31:0] dados_leitura;
    logic        s_valida;
    logic        s_pronta;
    logic [31:0] s_dados;
    logic [4:0]  s_indice;
    logic        s_ultimo;
    logic        ocupado;
    logic        erro;

    logic [31:0] rf [NUM_REGS];

    typedef struct {
        logic [31:0] d;
        logic [4:0]  i;
        logic        u;
    } word_t;

    word_t exp_q[$];
    word_t log_q[$];

    int checks = 0;
    int errors = 0;

    reg_dump_ctrl #(.PULAR_ZERO(1'b1)) dut (
        .Clock        (clk),
        .Reset_n      (rst_n),
        .Iniciar      (iniciar),
        .IndiceInicial(ind_ini),
        .IndiceFinal  (ind_fim),
        .regLeitura   (reg_leitura),
        .DadosLeitura (dados_leitura),
        .SaidaValida  (s_valida),
        .SaidaPronta  (s_pronta),
        .SaidaDados   (s_dados),
        .SaidaIndice  (s_indice),
        .SaidaUltimo  (s_ultimo),
        .Ocupado      (ocupado),
        .Erro         (erro)
    );

    assign dados_leitura = rf[reg_leitura];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Model: the word stream a dump of [ini..fim] must produce.
    task automatic expect_dump(input int ini, input int fim);
        int eff;
        logic [31:0] acc;
        eff = (ini == 0) ? 1 : ini;
        acc = 32'h0;
        if (eff <= fim) begin
            for (int k = eff; k <= fim; k++) begin
                exp_q.push_back('{d: 32'h100 + k, i: k[4:0], u: (k == fim) && !CK});
                acc = acc ^ (32'h100 + k);
            end
            if (CK) exp_q.push_back('{d: acc, i: 5'd0, u: 1'b1});
        end
    endtask

    task automatic start(input int ini, input int fim);
        iniciar = 1'b1;
        ind_ini = ini[4:0];
        ind_fim = fim[4:0];
        expect_dump(ini, fim);
        @(posedge clk); #1;
        iniciar = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!ocupado && !s_valida) break;
        end
        chk("dump_ends", {31'd0, ocupado}, 32'd0);
        chk("model_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valida"}, {31'd0, s_valida}, 32'd0);
        chk({tag, "_ultimo"}, {31'd0, s_ultimo}, 32'd0);
        chk({tag, "_ocupado"}, {31'd0, ocupado}, 32'd0);
        chk({tag, "_erro"}, {31'd0, erro}, 32'd0);
        chk({tag, "_dados"}, s_dados, 32'd0);
        chk({tag, "_indice"}, {27'd0, s_indice}, 32'd0);
        chk({tag, "_regleitura"}, {27'd0, reg_leitura}, 32'd0);
    endtask

    // Compare process: every handshake against the model, stability while stalled.
    logic        stall_q = 1'b0;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    logic        held_u;
    always @(negedge clk) begin
        if (rst_n && !ocupado) chk("regleitura_idle", {27'd0, reg_leitura}, 32'd0);
        if (rst_n && s_valida) begin
            if (stall_q) begin
                chk("stable_dados", s_dados, held_d);
                chk("stable_indice", {27'd0, s_indice}, {27'd0, held_i});
                chk("stable_ultimo", {31'd0, s_ultimo}, {31'd0, held_u});
            end
            if (s_pronta) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word_idx", {27'd0, s_indice}, 32'hFFFF_FFFF);
                end else begin
                    word_t w;
                    w = exp_q.pop_front();
                    chk("word_dados", s_dados, w.d);
                    chk("word_indice", {27'd0, s_indice}, {27'd0, w.i});
                    chk("word_ultimo", {31'd0, s_ultimo}, {31'd0, w.u});
                end
                log_q.push_back('{d: s_dados, i: s_indice, u: s_ultimo});
            end
            held_d = s_dados;
            held_i = s_indice;
            held_u = s_ultimo;
        end
        stall_q = rst_n && s_valida && !s_pronta;
    end

    initial begin
        for (int k = 0; k < NUM_REGS; k++) rf[k] = 32'h100 + k;
        rst_n    = 1'b0;
        iniciar  = 1'b0;
        ind_ini  = 5'd0;
        ind_fim  = 5'd0;
        s_pronta = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1;

        // Range 3..5: latency, addresses and the three words.
        log_q.delete();
        start(3, 5);
        @(negedge clk);
        chk("s1_regleitura_ler", {27'd0, reg_leitura}, 32'd3);
        chk("s1_valid_early", {31'd0, s_valida}, 32'd0);
        chk("s1_ocupado", {31'd0, ocupado}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s1_first_valid_lat2", {31'd0, s_valida}, 32'd1);
        chk("s1_first_dados", s_dados, 32'h103);
        wait_idle();
        chk("s1_count", log_q.size(), 32'd3 + {31'd0, CK});
        if (log_q.size() >= 3) begin
            chk("s1_w0_dados", log_q[0].d, 32'h103);
            chk("s1_w1_ultimo", {31'd0, log_q[1].u}, 32'd0);
            chk("s1_w2_indice", {27'd0, log_q[2].i}, 32'd5);
            chk("s1_w2_ultimo", {31'd0, log_q[2].u}, {31'd0, !CK});
        end

        // Range 0..0 with register 0 skipped: invalid, then cleared by a valid start.
        iniciar = 1'b1; ind_ini = 5'd0; ind_fim = 5'd0;
        @(posedge clk); #1;
        iniciar = 1'b0;
        @(negedge clk);
        chk("s2_erro_set", {31'd0, erro}, 32'd1);
        chk("s2_ocupado", {31'd0, ocupado}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("s2_no_valid", {31'd0, s_valida}, 32'd0);
            chk("s2_erro_sticky", {31'd0, erro}, 32'd1);
        end
        @(posedge clk); #1;
        start(2, 2);
        @(negedge clk);
        chk("s2_erro_cleared", {31'd0, erro}, 32'd0);
        wait_idle();

        // Range 30..31 with a 5-cycle stall on the first word; no wrap past 31.
        log_q.delete();
        s_pronta = 1'b0;
        start(30, 31);
        @(negedge clk);
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("s3_stall_valid", {31'd0, s_valida}, 32'd1);
            chk("s3_stall_dados", s_dados, 32'h11E);
            chk("s3_stall_indice", {27'd0, s_indice}, 32'd30);
            @(posedge clk); #1;
        end
        s_pronta = 1'b1;
        wait_idle();
        if (log_q.size() >= 2) chk("s3_last_indice", {27'd0, log_q[1].i}, 32'd31);
        else chk("s3_count", log_q.size(), 32'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("s3_no_wrap_valid", {31'd0, s_valida}, 32'd0);
            chk("s3_no_wrap_ocupado", {31'd0, ocupado}, 32'd0);
        end
        @(posedge clk); #1;

        // Range 1..31 interrupted by reset; a second start mid-dump is ignored.
        log_q.delete();
        start(1, 31);
        repeat (5) begin @(posedge clk); #1; end
        iniciar = 1'b1; ind_ini = 5'd5; ind_fim = 5'd6;
        @(posedge clk); #1;
        iniciar = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        s_pronta = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        rst_n = 1'b1;
        s_pronta = 1'b1;
        @(negedge clk);
        check_zero_outputs("s4_reset");
        if (log_q.size() >= 1) chk("s4_first_indice", {27'd0, log_q[0].i}, 32'd1);
        else chk("s4_some_words", log_q.size(), 32'd1);
        @(posedge clk); #1;
        start(4, 4);
        wait_idle();

`ifdef REG_DUMP_CHECKSUM_EN
        // Range 1..2 followed by the checksum word.
        log_q.delete();
        start(1, 2);
        wait_idle();
        if (log_q.size() == 3) begin
            chk("s5_ck_dados", log_q[2].d, 32'h003);
            chk("s5_ck_indice", {27'd0, log_q[2].i}, 32'd0);
            chk("s5_ck_ultimo", {31'd0, log_q[2].u}, 32'd1);
            chk("s5_w1_ultimo", {31'd0, log_q[1].u}, 32'd0);
        end else begin
            chk("s5_count", log_q.size(), 32'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
